// File: rtl/indirect_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// lc3b_types : shared LC-3b widths and the memory-class opcodes.
// indirect_mem_ctrl_if : data-memory request/response bus between the MEM-stage
//   sequencer (master) and the data memory (slave).
//   d_mem_read / d_mem_write  : request strobes, held until d_mem_resp
//   d_mem_address             : request address
//   d_mem_byte_enable         : write byte lanes ({hi, lo})
//   d_mem_resp                : memory completes the current access this cycle
//   d_mem_rdata               : read data, valid with d_mem_resp
// -----------------------------------------------------------------------------
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;
    typedef logic [2:0]  lc3b_reg;

    localparam lc3b_opcode OP_LDB  = 4'b0010;
    localparam lc3b_opcode OP_STB  = 4'b0011;
    localparam lc3b_opcode OP_LDR  = 4'b0110;
    localparam lc3b_opcode OP_STR  = 4'b0111;
    localparam lc3b_opcode OP_LDI  = 4'b1010;
    localparam lc3b_opcode OP_STI  = 4'b1011;
    localparam lc3b_opcode OP_TRAP = 4'b1111;
endpackage

interface indirect_mem_ctrl_if;
    import lc3b_types::*;

    logic        d_mem_read;
    logic        d_mem_write;
    lc3b_word    d_mem_address;
    logic [1:0]  d_mem_byte_enable;
    logic        d_mem_resp;
    lc3b_word    d_mem_rdata;

    modport master (
        output d_mem_read, d_mem_write, d_mem_address, d_mem_byte_enable,
        input  d_mem_resp, d_mem_rdata
    );

    modport slave (
        input  d_mem_read, d_mem_write, d_mem_address, d_mem_byte_enable,
        output d_mem_resp, d_mem_rdata
    );
endinterface

// File: rtl/indirect_mem_ctrl.sv
// -----------------------------------------------------------------------------
// indirect_mem_ctrl : MEM-stage data-memory sequencer for the pipelined LC-3b.
// Issues the single access of LDR/LDB/STR/STB/TRAP and the pointer-then-data
// pair of LDI/STI, stalls the pipeline until memory answers, and keeps a copy
// of the WB-stage result that the forwarding logic would otherwise lose while
// MEM is held on the indirect access.
// Ports:
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   valid_mem             : MEM stage holds a real instruction
//   opcode_mem            : MEM-stage opcode
//   address_mem           : effective address from EX
//   load_regfile_wb       : WB-stage regfile write enable
//   dest_wb, data_wb      : WB-stage destination and write data
//   mem                   : data-memory bus (master side)
//   indirectmux_sel       : MEM is on the second access of LDI/STI
//   stall_pipe            : instruction cannot leave MEM at the end of this cycle
//   save_load_regfile     : saved WB write enable (cleared on IND completion)
//   save_dest, save_data  : saved WB destination and data
// -----------------------------------------------------------------------------
module indirect_mem_ctrl
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid_mem,
    input  lc3b_opcode opcode_mem,
    input  lc3b_word   address_mem,
    input  logic       load_regfile_wb,
    input  lc3b_reg    dest_wb,
    input  lc3b_word   data_wb,
    indirect_mem_ctrl_if.master mem,
    output logic       indirectmux_sel,
    output logic       stall_pipe,
    output logic       save_load_regfile,
    output lc3b_reg    save_dest,
    output lc3b_word   save_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        IND  = 2'd2
    } state_t;

    state_t   state, state_next;
    lc3b_word ptr;
    logic     ptr_load;
    logic     save_capture;
    logic     save_clear;

    logic is_mem_op, is_ind_op, is_write_op;

    always_comb begin
        is_mem_op   = (opcode_mem == OP_LDB) || (opcode_mem == OP_STB) ||
                      (opcode_mem == OP_LDR) || (opcode_mem == OP_STR) ||
                      (opcode_mem == OP_LDI) || (opcode_mem == OP_STI) ||
                      (opcode_mem == OP_TRAP);
        is_ind_op   = (opcode_mem == OP_LDI) || (opcode_mem == OP_STI);
        is_write_op = (opcode_mem == OP_STB) || (opcode_mem == OP_STR);
    end

    // NOTE: async reset in the sensitivity list; every register gets a reset
    // value so the save_* outputs are defined from the first cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            ptr               <= '0;
            save_load_regfile <= 1'b0;
            save_dest         <= '0;
            save_data         <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values.
            state <= state_next;
            if (ptr_load) ptr <= mem.d_mem_rdata;
            if (save_capture) begin
                save_load_regfile <= load_regfile_wb;
                save_dest         <= dest_wb;
                save_data         <= data_wb;
            end else if (save_clear) begin
                save_load_regfile <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_next            = state;
        mem.d_mem_read        = 1'b0;
        mem.d_mem_write       = 1'b0;
        mem.d_mem_address     = '0;
        mem.d_mem_byte_enable = 2'b00;
        indirectmux_sel       = 1'b0;
        stall_pipe            = 1'b0;
        ptr_load              = 1'b0;
        save_capture          = 1'b0;
        save_clear            = 1'b0;

        // Gating on reset_n drops an in-flight request the instant reset is
        // asserted, even though IDLE would otherwise re-issue it from the
        // still-valid MEM inputs.
        if (reset_n) begin
            unique case (state)
                IDLE: begin
                    if (valid_mem && is_mem_op) begin
                        mem.d_mem_address = address_mem;
                        // STI's first access is the pointer read.
                        mem.d_mem_write   = is_write_op;
                        mem.d_mem_read    = ~is_write_op;
                        if (opcode_mem == OP_STB)
                            mem.d_mem_byte_enable = address_mem[0] ? 2'b10 : 2'b01;
                        else
                            mem.d_mem_byte_enable = 2'b11;

                        if (is_ind_op) begin
                            // The second access always follows, so hold MEM.
                            stall_pipe = 1'b1;
                            if (mem.d_mem_resp) begin
                                ptr_load     = 1'b1;
                                save_capture = 1'b1;
                                state_next   = IND;
                            end else begin
                                state_next   = PTR;
                            end
                        end else begin
                            stall_pipe = ~mem.d_mem_resp;
                        end
                    end
                end

                PTR: begin
                    mem.d_mem_read        = 1'b1;
                    mem.d_mem_address     = address_mem;
                    mem.d_mem_byte_enable = 2'b11;
                    stall_pipe            = 1'b1;
                    if (mem.d_mem_resp) begin
                        ptr_load     = 1'b1;
                        save_capture = 1'b1;
                        state_next   = IND;
                    end
                end

                IND: begin
                    indirectmux_sel       = 1'b1;
                    mem.d_mem_address     = ptr;
                    mem.d_mem_byte_enable = 2'b11;
                    mem.d_mem_write       = (opcode_mem == OP_STI);
                    mem.d_mem_read        = (opcode_mem != OP_STI);
                    stall_pipe            = ~mem.d_mem_resp;
                    if (mem.d_mem_resp) begin
                        save_clear = 1'b1;
                        state_next = IDLE;
                    end
                end

                default: state_next = IDLE;
            endcase
        end
    end

endmodule
